// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the load pipe and the store-commit pipe,
// with one outstanding load, registered memory commands and a store starvation guard.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_ready_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_data_valid_o,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              st_ready_o,
    input  logic [DATA_W-1:0] dmem_readData,
    output logic [ADDR_W-1:0] dmem_addressLoad,
    output logic [ADDR_W-1:0] dmem_addressStore,
    output logic [DATA_W-1:0] dmem_WriteData,
    output logic              dmem_readEn,
    output logic              dmem_writeEn,
    output logic              busy_o
);
    localparam int LW = $clog2(READ_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, LD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, ld_dv_q, ld_dv_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
    logic [DATA_W-1:0] st_data_q, st_data_d, ld_data_q, ld_data_d;
    logic              idle, starve_hit, ld_go, st_go;

    // The readies are mutually exclusive whenever both valids are up, so at most one grant per edge.
    always_comb begin
        idle       = state_q == IDLE;
        starve_hit = starve_q == SW'(STARVE_MAX);
        ld_ready_o = reset && idle && !(st_valid_i && starve_hit);
        st_ready_o = reset && !(idle && ld_valid_i && !starve_hit);
        ld_go      = ld_valid_i && ld_ready_o;
        st_go      = st_valid_i && st_ready_o;
        ld_dv_d    = !idle && lat_q == LW'(READ_LAT);
        ld_data_d  = ld_dv_d ? dmem_readData : ld_data_q;
        state_d    = ld_go ? LD_WAIT : (ld_dv_d ? IDLE : state_q);
        lat_d      = idle ? '0 : lat_q + 1'b1;
        starve_d   = st_go ? '0 : ((st_valid_i && !starve_hit) ? starve_q + 1'b1 : starve_q);
        rd_en_d    = ld_go;
        wr_en_d    = st_go;
        ld_addr_d  = ld_go ? ld_addr_i : ld_addr_q;
        st_addr_d  = st_go ? st_addr_i : st_addr_q;
        st_data_d  = st_go ? st_data_i : st_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            ld_dv_q   <= 1'b0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            ld_dv_q   <= ld_dv_d;
            ld_addr_q <= ld_addr_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign dmem_readEn       = rd_en_q;
    assign dmem_writeEn      = wr_en_q;
    assign dmem_addressLoad  = ld_addr_q;
    assign dmem_addressStore = st_addr_q;
    assign dmem_WriteData    = st_data_q;
    assign ld_data_o         = ld_data_q;
    assign ld_data_valid_o   = ld_dv_q;
    assign busy_o            = state_q == LD_WAIT;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector table, hand sequences and random traffic
// checked against a cycle-count based reference model of the arbiter.
module tb_dmem_port_arbiter;
    localparam int RL = 1;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid_i = 1'b0, st_valid_i = 1'b0;
    logic [63:0] ld_addr_i = '0, st_addr_i = '0, st_data_i = '0;
    logic        ld_ready_o, st_ready_o, ld_data_valid_o, dmem_readEn, dmem_writeEn, busy_o;
    logic [63:0] ld_data_o, dmem_readData, dmem_addressLoad, dmem_addressStore, dmem_WriteData;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(RL), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_ready_o(ld_ready_o),
        .ld_data_o(ld_data_o), .ld_data_valid_o(ld_data_valid_o),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
        .dmem_readData(dmem_readData), .dmem_addressLoad(dmem_addressLoad),
        .dmem_addressStore(dmem_addressStore), .dmem_WriteData(dmem_WriteData),
        .dmem_readEn(dmem_readEn), .dmem_writeEn(dmem_writeEn), .busy_o(busy_o)
    );

    function automatic logic [63:0] init_val(int i);
        return (i == 8) ? 64'hDEAD_BEEF : 64'h1000 + 64'(i);
    endfunction

    // Memory behind the port: data is only presented in the cycle READ_LAT after the read strobe.
    logic [63:0] mem_tb [16];
    logic [15:0] written = '0;
    logic [RL:0] rd_sh = '0;
    always @(posedge clk) begin
        rd_sh <= {rd_sh[RL-1:0], dmem_readEn};
        if (dmem_writeEn) begin
            mem_tb[dmem_addressStore[6:3]]  <= dmem_WriteData;
            written[dmem_addressStore[6:3]] <= 1'b1;
        end
    end
    always_comb
        dmem_readData = !rd_sh[RL-1] ? 64'hBAD0_BAD0_BAD0_BAD0 :
                        written[dmem_addressLoad[6:3]] ? mem_tb[dmem_addressLoad[6:3]] :
                        init_val(int'(dmem_addressLoad[6:3]));

    int          checks = 0, errors = 0;
    int          cyc, free_at, starve, due;
    bit          pend;
    logic [63:0] pend_dat, e_la, e_sa, e_sd, e_ld;
    logic [63:0] mem_m [16];
    logic        s_ldr, s_str;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; free_at = 0; starve = 0; pend = 0; due = 0;
        pend_dat = '0; e_la = '0; e_sa = '0; e_sd = '0; e_ld = '0;
    endtask

    // One clock: drive, check readies before the edge, check registered outputs after it.
    task automatic step(input bit ldv, input logic [63:0] lda, input bit stv,
                        input logic [63:0] sta, input logic [63:0] std);
        bit m_idle, m_hit, e_ldr, e_str, g_ld, g_st, e_dv;
        ld_valid_i = ldv; ld_addr_i = lda; st_valid_i = stv; st_addr_i = sta; st_data_i = std;
        #1;
        m_idle = cyc >= free_at;
        m_hit  = starve == SM;
        e_ldr  = m_idle && !(stv && m_hit);
        e_str  = !(m_idle && ldv && !m_hit);
        s_ldr  = ld_ready_o;
        s_str  = st_ready_o;
        chk("ld_ready", ld_ready_o, e_ldr);
        chk("st_ready", st_ready_o, e_str);
        g_ld = ldv && e_ldr;
        g_st = stv && e_str;
        if (g_st) starve = 0;
        else if (stv) starve = (starve + 1 > SM) ? SM : starve + 1;
        cyc++;
        if (g_ld) begin
            e_la = lda; free_at = cyc + RL + 1; due = free_at; pend = 1; pend_dat = mem_m[lda[6:3]];
        end
        if (g_st) begin
            e_sa = sta; e_sd = std; mem_m[sta[6:3]] = std;
        end
        @(posedge clk);
        #1;
        e_dv = pend && cyc == due;
        if (e_dv) begin
            e_ld = pend_dat; pend = 0;
        end
        chk("readEn", dmem_readEn, g_ld);
        chk("writeEn", dmem_writeEn, g_st);
        chk("addressLoad", dmem_addressLoad, e_la);
        chk("addressStore", dmem_addressStore, e_sa);
        chk("WriteData", dmem_WriteData, e_sd);
        chk("busy", busy_o, cyc < free_at);
        chk("ld_data_valid", ld_data_valid_o, e_dv);
        chk("ld_data", ld_data_o, e_ld);
        @(negedge clk);
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_ld_ready"}, ld_ready_o, 0);
        chk({nm, "_st_ready"}, st_ready_o, 0);
        chk({nm, "_readEn"}, dmem_readEn, 0);
        chk({nm, "_writeEn"}, dmem_writeEn, 0);
        chk({nm, "_addressLoad"}, dmem_addressLoad, 0);
        chk({nm, "_addressStore"}, dmem_addressStore, 0);
        chk({nm, "_WriteData"}, dmem_WriteData, 0);
        chk({nm, "_ld_data"}, ld_data_o, 0);
        chk({nm, "_ld_data_valid"}, ld_data_valid_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
    endtask

    task automatic rst_hold(string nm, int n);
        reset = 1'b0; ld_valid_i = 1'b1; st_valid_i = 1'b1;
        #1;
        check_zero(nm);
        repeat (n) @(negedge clk);
        #1;
        check_zero(nm);
        ld_valid_i = 1'b0; st_valid_i = 1'b0;
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit ldv; logic [63:0] lda; bit stv; logic [63:0] sta; logic [63:0] std;
        bit e_ldr, e_str, e_rd, e_wr, e_busy, e_dv; logic [63:0] e_dat;
    } vec_t;
    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          ldv lda     stv sta     std      ldr str rd wr busy dv dat
        tbl[0]  = '{1, 64'h40, 0, 64'h0,  64'h0,    1, 0, 1, 0, 1, 0, 64'h0};
        tbl[1]  = '{0, 64'h0,  0, 64'h0,  64'h0,    0, 1, 0, 0, 1, 0, 64'h0};
        tbl[2]  = '{0, 64'h0,  0, 64'h0,  64'h0,    0, 1, 0, 0, 0, 1, 64'hDEAD_BEEF};
        tbl[3]  = '{0, 64'h0,  1, 64'h0,  64'h1,    1, 1, 0, 1, 0, 0, 64'h0};
        tbl[4]  = '{0, 64'h0,  1, 64'h8,  64'h2,    1, 1, 0, 1, 0, 0, 64'h0};
        tbl[5]  = '{0, 64'h0,  1, 64'h10, 64'h3,    1, 1, 0, 1, 0, 0, 64'h0};
        tbl[6]  = '{0, 64'h0,  1, 64'h18, 64'h4,    1, 1, 0, 1, 0, 0, 64'h0};
        tbl[7]  = '{0, 64'h0,  0, 64'h0,  64'h0,    1, 1, 0, 0, 0, 0, 64'h0};
        tbl[8]  = '{1, 64'h20, 0, 64'h0,  64'h0,    1, 0, 1, 0, 1, 0, 64'h0};
        tbl[9]  = '{0, 64'h0,  1, 64'h20, 64'hABCD, 0, 1, 0, 1, 1, 0, 64'h0};
        tbl[10] = '{0, 64'h0,  0, 64'h0,  64'h0,    0, 1, 0, 0, 0, 1, 64'h1004};
        tbl[11] = '{1, 64'h20, 0, 64'h0,  64'h0,    1, 0, 1, 0, 1, 0, 64'h0};
        tbl[12] = '{0, 64'h0,  0, 64'h0,  64'h0,    0, 1, 0, 0, 1, 0, 64'h0};
        tbl[13] = '{0, 64'h0,  0, 64'h0,  64'h0,    0, 1, 0, 0, 0, 1, 64'hABCD};
        for (int i = 0; i < 16; i++) mem_m[i] = init_val(i);
        model_reset();
        @(negedge clk);
        rst_hold("reset", 3);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].ldv, tbl[i].lda, tbl[i].stv, tbl[i].sta, tbl[i].std);
            chk($sformatf("vec%0d_ld_ready", i), s_ldr, tbl[i].e_ldr);
            chk($sformatf("vec%0d_st_ready", i), s_str, tbl[i].e_str);
            chk($sformatf("vec%0d_readEn", i), dmem_readEn, tbl[i].e_rd);
            chk($sformatf("vec%0d_writeEn", i), dmem_writeEn, tbl[i].e_wr);
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("vec%0d_dv", i), ld_data_valid_o, tbl[i].e_dv);
            if (tbl[i].e_dv) chk($sformatf("vec%0d_ld_data", i), ld_data_o, tbl[i].e_dat);
        end

        // Store valid only while loads are grantable: four denials saturate the guard.
        for (int r = 0; r < SM; r++) begin
            step(1, 64'h30, 1, 64'h78, 64'h55);
            chk("starve_load_wins", dmem_readEn, 1);
            repeat (RL + 1) step(0, 64'h0, 0, 64'h0, 64'h0);
        end
        step(1, 64'h30, 1, 64'h78, 64'h55);
        chk("starve_ld_ready", s_ldr, 0);
        chk("starve_st_ready", s_str, 1);
        chk("starve_store_wins", dmem_writeEn, 1);
        chk("starve_no_read", dmem_readEn, 0);
        step(1, 64'h30, 1, 64'h78, 64'h66);
        chk("starve_cleared_ld_ready", s_ldr, 1);
        chk("starve_cleared_st_ready", s_str, 0);
        repeat (RL + 1) step(0, 64'h0, 0, 64'h0, 64'h0);

        // Reset while the load is outstanding drops it.
        step(1, 64'h8, 0, 64'h0, 64'h0);
        chk("midrst_readEn", dmem_readEn, 1);
        rst_hold("midrst", 2);
        repeat (3) step(0, 64'h0, 0, 64'h0, 64'h0);
        step(1, 64'h8, 0, 64'h0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 64'h0);
        chk("midrst_reload_dv", ld_data_valid_o, 1);
        chk("midrst_reload_data", ld_data_o, 64'h2);

        for (int i = 0; i < 24; i++) begin
            step(1, 64'(i % 16) << 3, 1, 64'(15 - i % 16) << 3, 64'h9000 + 64'(i));
            chk("both_excl", dmem_readEn & dmem_writeEn, 0);
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 64'($urandom_range(0, 15)) << 3,
                 1'($urandom_range(0, 1)), 64'($urandom_range(0, 15)) << 3,
                 {32'($urandom), 32'($urandom)});
            chk("rand_excl", dmem_readEn & dmem_writeEn, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
